// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: FSM state encoding and the width/digit legality check.
`ifndef ARITH_PKG_SV
`define ARITH_PKG_SV

`define ARITH_CHECK_DIV(W, D) \
  if (((W) % (D)) != 0) begin : g_bad_digit \
    $error("WIDTH must be an exact multiple of DIGIT"); \
  end

package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`endif

// File: rtl/sub_digit.sv
// Combinational DIGIT-bit ripple-borrow subtractor slice: d = x - y - bi.
module sub_digit #(
  parameter int unsigned DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             bi,
  output logic [DIGIT-1:0] d,
  output logic             bo
);

  logic [DIGIT:0] bc;

  always_comb begin
    bc    = '0;
    d     = '0;
    bc[0] = bi;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      d[i]    = x[i] ^ y[i] ^ bc[i];
      bc[i+1] = (~x[i] & y[i]) | (~x[i] & bc[i]) | (y[i] & bc[i]);
    end
    bo = bc[DIGIT];
  end

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin, DIGIT bits per cycle, with flag outputs.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int unsigned LAST = NDIG - 1;

  `ARITH_CHECK_DIV(WIDTH, DIGIT)

  if (WIDTH < 2) begin : g_bad_width
    $error("WIDTH must be at least 2");
  end

  state_t state, state_nx;

  logic [WIDTH-1:0]       sa, sb, res, res_nx;
  logic [WIDTH+DIGIT-1:0] res_cat;
  logic [CW-1:0]          cnt;
  logic                   br, amsb, bmsb;
  logic [DIGIT-1:0]       sd;
  logic                   sbo;
  logic                   accept, last;

  sub_digit #(.DIGIT(DIGIT)) u_slice (
    .x  (sa[DIGIT-1:0]),
    .y  (sb[DIGIT-1:0]),
    .bi (br),
    .d  (sd),
    .bo (sbo)
  );

  assign accept  = start && (state != RUN);
  assign last    = (cnt == CW'(LAST));
  // Slice result enters from the top; the concatenation also covers DIGIT == WIDTH.
  assign res_cat = {sd, res};
  assign res_nx  = res_cat[WIDTH+DIGIT-1:DIGIT];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = DONE;
      DONE:    state_nx = start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sa   <= '0;
      sb   <= '0;
      res  <= '0;
      cnt  <= '0;
      br   <= 1'b0;
      amsb <= 1'b0;
      bmsb <= 1'b0;
      diff <= '0;
      bout <= 1'b0;
      ovf  <= 1'b0;
      zero <= 1'b0;
    end else if (accept) begin
      sa   <= a;
      sb   <= b;
      br   <= bin;
      cnt  <= '0;
      amsb <= a[WIDTH-1];
      bmsb <= b[WIDTH-1];
    end else if (state == RUN) begin
      sa  <= sa >> DIGIT;
      sb  <= sb >> DIGIT;
      res <= res_nx;
      br  <= sbo;
      cnt <= cnt + 1'b1;
      if (last) begin
        diff <= res_nx;
        bout <= sbo;
        ovf  <= (amsb != bmsb) && (res_nx[WIDTH-1] != amsb);
        zero <= (res_nx == '0);
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor at DIGIT=1 and DIGIT=4 (WIDTH=8).
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       start1 = 1'b0, bin1 = 1'b0;
  logic [7:0] a1 = '0, b1 = '0;
  logic       busy1, done1, bout1, ovf1, zero1;
  logic [7:0] diff1;

  logic       start4 = 1'b0, bin4 = 1'b0;
  logic [7:0] a4 = '0, b4 = '0;
  logic       busy4, done4, bout4, ovf4, zero4;
  logic [7:0] diff4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8), .DIGIT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .bin(bin1),
    .busy(busy1), .done(done1), .diff(diff1), .bout(bout1), .ovf(ovf1), .zero(zero1)
  );

  serial_subtractor #(.WIDTH(8), .DIGIT(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4), .ovf(ovf4), .zero(zero4)
  );

  // Wait (from cycle 1) for done on dut1, checking busy along the way; returns done cycle.
  task automatic wait_done1(input string tag, output int lat);
    lat = 1;
    while (done1 !== 1'b1 && lat < 40) begin
      checks++;
      if (busy1 !== 1'b1) begin
        failures++;
        $display("FAIL %s_busy cycle=%0d got=%b exp=1", tag, lat, busy1);
      end
      @(negedge clk);
      lat++;
    end
    checks++;
    if (done1 !== 1'b1 || busy1 !== 1'b0) begin
      failures++;
      $display("FAIL %s_done_timeout done=%b busy=%b exp done=1 busy=0", tag, done1, busy1);
    end
  endtask

  task automatic check1(input string tag, input int lat, input int elat, input logic [7:0] ed,
                        input logic eb, input logic eo, input logic ez);
    checks++;
    if (lat !== elat) begin
      failures++;
      $display("FAIL %s_latency got=%0d exp=%0d", tag, lat, elat);
    end
    checks++;
    if ({diff1, bout1, ovf1, zero1} !== {ed, eb, eo, ez}) begin
      failures++;
      $display("FAIL %s_result got diff=%h b=%b o=%b z=%b exp diff=%h b=%b o=%b z=%b",
               tag, diff1, bout1, ovf1, zero1, ed, eb, eo, ez);
    end
  endtask

  task automatic op1(input string tag, input logic [7:0] a, input logic [7:0] b, input logic bi,
                     input logic [7:0] ed, input logic eb, input logic eo, input logic ez);
    int lat;
    @(negedge clk);
    a1 = a; b1 = b; bin1 = bi; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    wait_done1(tag, lat);
    check1(tag, lat, 9, ed, eb, eo, ez);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({busy1, done1, diff1, bout1, ovf1, zero1} !== 13'd0 ||
        {busy4, done4, diff4, bout4, ovf4, zero4} !== 13'd0) begin
      failures++;
      $display("FAIL reset_outputs got1=%h got4=%h exp=0",
               {busy1, done1, diff1, bout1, ovf1, zero1}, {busy4, done4, diff4, bout4, ovf4, zero4});
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    op1("sub_5_3",    8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);
    op1("sub_0_1",    8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0);
    op1("sub_80_1",   8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0);
    op1("sub_10_f_1", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
    op1("sub_f_f_1",  8'h0F, 8'h0F, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_ignore_busy();
    int lat;
    @(negedge clk);
    a1 = 8'h05; b1 = 8'h03; bin1 = 1'b0; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a1 = 8'hFF; b1 = 8'h00; bin1 = 1'b1; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    lat = 4;
    while (done1 !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check1("ignore_busy", lat, 9, 8'h02, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (busy1 !== 1'b0 || done1 !== 1'b0) begin
      failures++;
      $display("FAIL ignore_busy_idle busy=%b done=%b exp 0 0", busy1, done1);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    a1 = 8'h80; b1 = 8'h01; bin1 = 1'b0; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    wait_done1("b2b_first", lat);
    check1("b2b_first", lat, 9, 8'h7F, 1'b0, 1'b1, 1'b0);
    a1 = 8'h33; b1 = 8'h11; bin1 = 1'b1; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    wait_done1("b2b_second", lat);
    check1("b2b_second", lat, 9, 8'h21, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_run();
    int lat;
    @(negedge clk);
    a1 = 8'h0F; b1 = 8'h0F; bin1 = 1'b0; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy1, done1, diff1, bout1, ovf1, zero1} !== 13'd0) begin
      failures++;
      $display("FAIL mid_reset_outputs got=%h exp=0", {busy1, done1, diff1, bout1, ovf1, zero1});
    end
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (done1 !== 1'b0 || busy1 !== 1'b0) begin
        failures++;
        $display("FAIL mid_reset_quiet cycle=%0d done=%b busy=%b exp 0 0", i, done1, busy1);
      end
      @(negedge clk);
    end
    op1("after_reset", 8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic op4(input string tag, input logic [7:0] a, input logic [7:0] b, input logic bi,
                     input int elat, input logic [7:0] ed, input logic eb, input logic eo,
                     input logic ez);
    int lat;
    @(negedge clk);
    a4 = a; b4 = b; bin4 = bi; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    lat = 1;
    while (done4 !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== elat || done4 !== 1'b1) begin
      failures++;
      $display("FAIL %s_latency got=%0d exp=%0d", tag, lat, elat);
    end
    checks++;
    if ({diff4, bout4, ovf4, zero4} !== {ed, eb, eo, ez}) begin
      failures++;
      $display("FAIL %s_result a=%h b=%h bin=%b got diff=%h b=%b o=%b z=%b exp diff=%h b=%b o=%b z=%b",
               tag, a, b, bi, diff4, bout4, ovf4, zero4, ed, eb, eo, ez);
    end
  endtask

  task automatic test_digit4();
    logic [8:0] full;
    logic [7:0] ra, rb;
    logic       rbi;
    op4("d4_a5_5a", 8'hA5, 8'h5A, 1'b0, 3, 8'h4B, 1'b0, 1'b1, 1'b0);
    for (int n = 0; n < 1000; n++) begin
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      rbi  = 1'($urandom);
      full = {1'b0, ra} - {1'b0, rb} - {8'd0, rbi};
      op4("d4_sweep", ra, rb, rbi, 3, full[7:0], full[8],
          (ra[7] != rb[7]) && (full[7] != ra[7]), full[7:0] == 8'h00);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid_run();
    test_digit4();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
